sfp_link_ctrl: RTL

SFP_LINK_CTRL -- requirements
Module: sfp_link_ctrl

---
 rtl/sfp_link_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sfp_link_ctrl.sv
// SFP/transceiver bring-up sequencer: PHY reset, PLL/TX/RX lock waits, stability qualification, retry/fail.
// Latency: status inputs reach the FSM after a 2-flop synchronizer; every output is registered with the state.
// Backpressure: none; status is level-sampled every cycle and restart is a one-cycle synchronous request.
module sfp_link_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 5000000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       reconfig_busy,
  input  logic       tx_ready,
  input  logic       rx_ready,
  input  logic       rx_data_ready,
  input  logic       restart,
  output logic       phy_rst,
  output logic       datapath_rst,
  output logic       link_up,
  output logic       link_fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] RESET_PHY = 3'd0;
  localparam logic [2:0] WAIT_PLL  = 3'd1;
  localparam logic [2:0] WAIT_TX   = 3'd2;
  localparam logic [2:0] WAIT_RX   = 3'd3;
  localparam logic [2:0] STABLE    = 3'd4;
  localparam logic [2:0] LINK_UP   = 3'd5;
  localparam logic [2:0] FAIL      = 3'd6;

  // Terminal counts for the shared 24-bit timer.
  localparam logic [23:0] RST_LAST    = 24'(RST_CYCLES - 1);
  localparam logic [23:0] LOCK_LAST   = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] STABLE_LAST = 24'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

  // Synchronizer bit order: {pll_locked, reconfig_busy, tx_ready, rx_ready, rx_data_ready}
  logic [4:0]  sync_1;
  logic [4:0]  sync_2;
  logic        pll_s;
  logic        busy_s;
  logic        tx_s;
  logic        rx_s;
  logic        rxd_s;
  logic        all_good;

  logic [23:0] timer;
  logic [23:0] timer_nxt;
  logic [2:0]  state_nxt;
  logic [3:0]  retry_nxt;
  logic        retry_take;

  logic        phy_rst_nxt;
  logic        datapath_rst_nxt;
  logic        link_up_nxt;
  logic        link_fail_nxt;

  // Two-flop synchronizers for all PHY status inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {pll_locked, reconfig_busy, tx_ready, rx_ready, rx_data_ready};
      sync_2 <= sync_1;
    end
  end

  assign pll_s  = sync_2[4];
  assign busy_s = sync_2[3];
  assign tx_s   = sync_2[2];
  assign rx_s   = sync_2[1];
  assign rxd_s  = sync_2[0];

  // Everything the link needs to be considered healthy at once.
  assign all_good = pll_s && !busy_s && tx_s && rx_s && rxd_s;

  // State, timer, retry counter and registered outputs all update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RESET_PHY;
      timer        <= '0;
      retry_cnt    <= '0;
      phy_rst      <= 1'b1;
      datapath_rst <= 1'b1;
      link_up      <= 1'b0;
      link_fail    <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      retry_cnt    <= retry_nxt;
      phy_rst      <= phy_rst_nxt;
      datapath_rst <= datapath_rst_nxt;
      link_up      <= link_up_nxt;
      link_fail    <= link_fail_nxt;
    end
  end

  // Next-state logic: per-state exits, timeout retry path, restart override last so it wins.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer + 24'd1;
    retry_nxt  = retry_cnt;
    retry_take = 1'b0;

    case (state)
      RESET_PHY: begin
        if (timer == RST_LAST) begin
          state_nxt = WAIT_PLL;
          timer_nxt = '0;
        end
      end
      WAIT_PLL: begin
        if (pll_s && !busy_s) begin
          state_nxt = WAIT_TX;
          timer_nxt = '0;
        end else if (timer == LOCK_LAST) begin
          retry_take = 1'b1;
        end
      end
      WAIT_TX: begin
        if (tx_s) begin
          state_nxt = WAIT_RX;
          timer_nxt = '0;
        end else if (timer == LOCK_LAST) begin
          retry_take = 1'b1;
        end
      end
      WAIT_RX: begin
        if (rx_s && rxd_s) begin
          state_nxt = STABLE;
          timer_nxt = '0;
        end else if (timer == LOCK_LAST) begin
          retry_take = 1'b1;
        end
      end
      STABLE: begin
        // Any drop restarts qualification from WAIT_RX without costing a retry.
        if (!all_good) begin
          state_nxt = WAIT_RX;
          timer_nxt = '0;
        end else if (timer == STABLE_LAST) begin
          state_nxt = LINK_UP;
          timer_nxt = '0;
        end
      end
      LINK_UP: begin
        timer_nxt = '0;
        // PLL/TX/calibration loss needs a full PHY reset; RX-only loss just re-locks.
        if (!pll_s || !tx_s || busy_s) begin
          retry_take = 1'b1;
        end else if (!rx_s || !rxd_s) begin
          state_nxt = WAIT_RX;
        end
      end
      FAIL: begin
        timer_nxt = '0;
      end
      default: begin
        state_nxt = RESET_PHY;
        timer_nxt = '0;
      end
    endcase

    // Counter only increments below the limit, so it saturates and never wraps.
    if (retry_take) begin
      timer_nxt = '0;
      if (retry_cnt < RETRY_MAX) begin
        retry_nxt = retry_cnt + 4'd1;
        state_nxt = RESET_PHY;
      end else begin
        state_nxt = FAIL;
      end
    end

    if (restart) begin
      state_nxt = RESET_PHY;
      timer_nxt = '0;
      retry_nxt = '0;
    end
  end

  // Output decode from the next state so outputs register together with the state.
  always_comb begin
    phy_rst_nxt      = (state_nxt == RESET_PHY);
    datapath_rst_nxt = (state_nxt != LINK_UP);
    link_up_nxt      = (state_nxt == LINK_UP);
    link_fail_nxt    = (state_nxt == FAIL);
  end

endmodule
